// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU EX stage and the debug/loader port.
package dmem_arbiter_pkg;

    localparam int unsigned ARB_STARVE_LIMIT_DEF = 8;
    localparam int unsigned ARB_CNT_W_DEF        = 8;
    localparam int unsigned DMEM_LANES           = 4;
    localparam int unsigned DMEM_DATA_W          = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    // Write payload shared by both requesters and the dmem side.
    typedef struct packed {
        logic [DMEM_LANES-1:0]  we;
        logic [DMEM_DATA_W-1:0] data;
    } dmem_wr_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Fixed-priority dmem arbiter: CPU first, debug port in CPU-idle cycles,
// with a starvation counter that forces a one-cycle debug grant and stalls the CPU.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
    parameter int unsigned CNT_W        = ARB_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_access,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rd_data,
    input  logic              dbg_req,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wr_data,
    output logic              dbg_gnt,
    output logic              dbg_rd_valid,
    output logic [31:0]       dbg_rd_data,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_rd_data;
    logic             w_limit_hit;
    logic             w_grant;
    dmem_wr_t         w_cpu_wr;
    dmem_wr_t         w_dbg_wr;
    dmem_wr_t         w_mem_wr;

    assign w_limit_hit = (r_cnt >= CNT_W'(STARVE_LIMIT));
    assign w_grant     = dbg_req && (r_state == ARB_IDLE) && (!cpu_access || w_limit_hit);

    // Next state and starvation counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ARB_IDLE: if (w_grant && (dbg_we == 4'b0000)) w_state_nxt = ARB_RESP;
            ARB_RESP: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
        if (dbg_req && !w_grant) begin
            w_cnt_nxt = w_limit_hit ? CNT_W'(STARVE_LIMIT) : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ARB_RESP) r_rd_data <= mem_rd_data;
        end
    end

    // Memory-side steering; an idle CPU never writes.
    always_comb begin
        w_cpu_wr.we   = cpu_access ? cpu_we : 4'b0000;
        w_cpu_wr.data = cpu_wr_data;
        w_dbg_wr.we   = dbg_we;
        w_dbg_wr.data = dbg_wr_data;
        w_mem_wr      = w_grant ? w_dbg_wr : w_cpu_wr;
        mem_addr      = w_grant ? dbg_addr : cpu_addr;
        mem_we        = w_mem_wr.we;
        mem_wr_data   = w_mem_wr.data;
        dbg_gnt       = w_grant;
        cpu_stall     = w_grant && cpu_access;
    end

    // Read data arrives during RESP (1-cycle dmem latency) and is held afterwards.
    assign dbg_rd_valid = (r_state == ARB_RESP);
    assign dbg_rd_data  = dbg_rd_valid ? mem_rd_data : r_rd_data;
    assign cpu_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a dmem behavioural model, a transaction-level reference
// of the arbitration rules, directed scenarios and a randomized traffic phase.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int          STARVE = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_access;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wr_data;
    logic              cpu_stall;
    logic [31:0]       cpu_rd_data;
    logic              dbg_req;
    logic [3:0]        dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wr_data;
    logic              dbg_gnt;
    logic              dbg_rd_valid;
    logic [31:0]       dbg_rd_data;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_access(cpu_access), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_stall(cpu_stall), .cpu_rd_data(cpu_rd_data),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_gnt(dbg_gnt), .dbg_rd_valid(dbg_rd_valid), .dbg_rd_data(dbg_rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Environment: four byte-lane banks, synchronous read-before-write.
    logic [31:0] dmem [64];
    always @(posedge clk) begin
        mem_rd_data <= dmem[mem_addr[7:2]];
        for (int l = 0; l < 4; l++)
            if (mem_we[l]) dmem[mem_addr[7:2]][8*l +: 8] <= mem_wr_data[8*l +: 8];
    end

    // Reference state: shadow memory plus the requester-visible arbitration facts.
    logic [31:0] ref_mem [64];
    int          m_cnt;
    bit          m_out;
    logic [31:0] m_rd_exp;
    logic [31:0] m_hold;
    logic [31:0] m_prev_rd;
    bit          m_prev_ok;
    bit          m_g;
    logic        obs_gnt;
    logic [31:0] obs_cpu_rd;
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_out  = 1'b0;
        m_hold = 32'h0;
    endtask

    // One clock cycle: predict and check at negedge, advance the reference after posedge.
    task automatic step();
        logic        g;
        logic [3:0]  ewe;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [31:0] rd;
        @(negedge clk);
        g     = (rst_n === 1'b1) && dbg_req && !m_out && (!cpu_access || m_cnt == STARVE);
        ewe   = g ? dbg_we : (cpu_access ? cpu_we : 4'h0);
        eaddr = g ? dbg_addr : cpu_addr;
        ewd   = g ? dbg_wr_data : cpu_wr_data;
        chk("dbg_gnt",      32'(dbg_gnt),      32'(g));
        chk("cpu_stall",    32'(cpu_stall),    32'(g && cpu_access));
        chk("mem_we",       32'(mem_we),       32'(ewe));
        chk("mem_addr",     mem_addr,          eaddr);
        chk("mem_wr_data",  mem_wr_data,       ewd);
        chk("dbg_rd_valid", 32'(dbg_rd_valid), 32'(m_out));
        chk("dbg_rd_data",  dbg_rd_data,       m_out ? m_rd_exp : m_hold);
        if (m_prev_ok) chk("cpu_rd_data", cpu_rd_data, m_prev_rd);
        obs_gnt    = dbg_gnt;
        obs_cpu_rd = cpu_rd_data;
        m_g        = g;
        @(posedge clk);
        rd = ref_mem[eaddr[7:2]];
        if (m_out) m_hold = m_rd_exp;
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            m_out    = g && (dbg_we == 4'h0);
            m_rd_exp = rd;
            if (dbg_req && !g) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
            else               m_cnt = 0;
        end
        for (int l = 0; l < 4; l++)
            if (ewe[l]) ref_mem[eaddr[7:2]][8*l +: 8] = ewd[8*l +: 8];
        m_prev_rd = rd;
        m_prev_ok = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        cpu_access = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wr_data = '0;
        dbg_req = 1'b0; dbg_we = 4'h0; dbg_addr = '0; dbg_wr_data = '0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [5:0] w;
        w = 6'($urandom_range(0, 63));
        return {24'h0, w, 2'b00};
    endfunction

    int first;
    int ngnt;

    initial begin
        tests = 0; fails = 0; m_prev_ok = 1'b0; m_prev_rd = '0; m_rd_exp = '0; m_g = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = dmem[i];
        end
        dmem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Debug read of 0x40 with the CPU idle.
        dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h40;
        step();
        chk("rd_gnt_same_cycle", 32'(obs_gnt), 32'h1);
        dbg_req = 1'b0;
        step();
        chk("rd_data_0x40", dbg_rd_data, 32'hDEAD_BEEF);
        step();

        // Continuous CPU traffic, debug held: forced grant on the STARVE-th cycle.
        cpu_access = 1'b1; cpu_we = 4'h0;
        dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h80;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            cpu_addr = rnd_addr();
            step();
            if (obs_gnt && first < 0) first = i;
            if (m_g) dbg_req = 1'b0;
        end
        chk("starve_first_gnt", 32'(first), 32'(STARVE));
        idle_inputs();
        step();

        // Debug byte-2 write to 0x10, then CPU LW 0x10.
        dbg_req = 1'b1; dbg_we = 4'b0100; dbg_addr = 32'h10; dbg_wr_data = 32'h00AB_0000;
        step();
        chk("wr_gnt", 32'(obs_gnt), 32'h1);
        idle_inputs();
        step();
        chk("wr_no_rd_valid", 32'(dbg_rd_valid), 32'h0);
        cpu_access = 1'b1; cpu_addr = 32'h10;
        step();
        idle_inputs();
        step();
        chk("lw_byte2", 32'(obs_cpu_rd[23:16]), 32'hAB);

        // Back-to-back reads held asserted: grants every other cycle.
        dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h40;
        ngnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_gnt) ngnt++;
        end
        chk("b2b_grants", 32'(ngnt), 32'd3);
        idle_inputs();
        step();
        step();

        // Drop after 3 denied cycles, reassert: counter restarts.
        cpu_access = 1'b1;
        dbg_req = 1'b1; dbg_we = 4'b0001; dbg_addr = 32'h20; dbg_wr_data = 32'h55;
        for (int i = 0; i < 3; i++) step();
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_gnt && first < 0) first = i;
            if (m_g) dbg_req = 1'b0;
        end
        chk("drop_restart_gnt", 32'(first), 32'(STARVE));
        idle_inputs();
        step();

        // Reset during RESP drops dbg_rd_valid asynchronously.
        dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h44;
        step();
        idle_inputs();
        chk("resp_before_reset", 32'(dbg_rd_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_rd_valid", 32'(dbg_rd_valid), 32'h0);
        chk("reset_rd_data",  dbg_rd_data,       32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        cpu_access = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h30; cpu_wr_data = 32'hCAFE_F00D;
        step();
        idle_inputs();
        step();

        // Randomized mixed traffic.
        for (int n = 0; n < 3000; n++) begin
            cpu_access  = ($urandom_range(0, 99) < 60);
            cpu_we      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cpu_addr    = rnd_addr();
            cpu_wr_data = $urandom;
            if (!dbg_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    dbg_req     = 1'b1;
                    dbg_we      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    dbg_addr    = rnd_addr();
                    dbg_wr_data = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) begin
                dbg_req = 1'b0;
            end
            step();
            if (m_g) dbg_req = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-lane data memory (four 8-bit dmem banks, synchronous read, 1-cycle latency) between the CPU execution stage and a debug/loader port.
- The CPU has fixed priority. The debug port is served in CPU-idle cycles.
- A starvation counter forces a debug grant after STARVE_LIMIT denied cycles and stalls the CPU for that one cycle.
- Sits between the EX-stage dmem drive logic and the dmem_0..3 instances.

Parameters:
- ADDR_W, 32, width of cpu/dbg/mem address buses.
- STARVE_LIMIT, 8, consecutive denied debug-request cycles before a forced grant (1..255).
- CNT_W, 8, width of starvation counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cpu_access  input  1  CPU load or store present in EX this cycle
- cpu_we  input  4  CPU byte-lane write enables
- cpu_addr  input  ADDR_W  CPU dmem address
- cpu_wr_data  input  32  CPU lane-aligned store data
- cpu_stall  output  1  CPU must hold EX/PC this cycle (forced debug grant)
- cpu_rd_data  output  32  load data to WB stage
- dbg_req  input  1  debug request, level, held until dbg_gnt
- dbg_we  input  4  debug byte-lane write enables (0000 = read)
- dbg_addr  input  ADDR_W  debug address
- dbg_wr_data  input  32  debug write data
- dbg_gnt  output  1  debug access issued this cycle
- dbg_rd_valid  output  1  debug read data valid
- dbg_rd_data  output  32  debug read data
- mem_we  output  4  to dmem lane write enables
- mem_addr  output  ADDR_W  to dmem address
- mem_wr_data  output  32  to dmem lanes {3,2,1,0}
- mem_rd_data  input  32  from dmem lanes {3,2,1,0}

Behaviour:
- Reset: state=IDLE, starve_cnt=0, dbg_rd_valid=0, dbg_rd_data=0.
- Combinational outputs (cpu_stall, dbg_gnt, mem_*, cpu_rd_data) evaluate to 0 under reset with dbg_req=0 and cpu_access=0.
- States:
  - IDLE: no debug read outstanding.
  - RESP: debug read issued last cycle.
- grant = dbg_req && state==IDLE && (!cpu_access || starve_cnt==STARVE_LIMIT).
  - Grant is combinational, same cycle.
  - No grant in RESP: one outstanding debug read max.
- Grant cycle:
  - mem_we/addr/wr_data = dbg_*, dbg_gnt=1.
  - cpu_stall = cpu_access; the CPU re-presents the same access next cycle.
- Non-grant cycle:
  - mem_* = cpu_*.
  - mem_we forced to 0000 when cpu_access=0.
  - cpu_stall=0.
- cpu_rd_data = mem_rd_data always (CPU WB samples 1 cycle after its own access).
- Read completion:
  - A grant with dbg_we==0000 moves the FSM to RESP.
  - In RESP: dbg_rd_valid=1 (registered), dbg_rd_data = mem_rd_data captured; then return to IDLE.
- Write grant (dbg_we≠0000): stays IDLE; no rd_valid pulse.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle dbg_req=1 and no grant (including RESP cycles).
  - Clears to 0 on grant or when dbg_req=0.
- Forced grant:
  - Occurs at most once per STARVE_LIMIT+1 cycles under continuous CPU traffic.
  - CPU progress guaranteed ≥ STARVE_LIMIT accesses between forced grants.
- Simultaneous events:
  - dbg_req rising with cpu_access=0 → grant same cycle (zero wait).
  - cpu_access and dbg_req with cnt<limit → CPU wins, counter +1.
- dbg_req dropped before grant: request abandoned, counter cleared, no side effects.
- Reset mid-RESP: dbg_rd_valid drops immediately; the pending read is lost; the requester must re-issue.
- No address decode here; UART/GPIO/counter MMIO decode stays in cpu_top; arbiter sees dmem-relative addresses only.

Decomposition:
- Shared define file additions: state encodings (ARB_IDLE, ARB_RESP) and default STARVE_LIMIT constant.
- Single module; no sub-module. Counter and FSM are small enough to stay inline.

Test Plan:
- CPU idle, dbg read addr 0x40 (mem holds 0xDEADBEEF) → dbg_gnt same cycle, dbg_rd_valid=1 next cycle with 0xDEADBEEF, cpu_stall never 1.
- cpu_access=1 every cycle, dbg_req held from cycle 0, STARVE_LIMIT=8 → dbg_gnt and cpu_stall both 1 in cycle 8 only; mem_addr=dbg_addr that cycle; counter 0 after.
- Debug write dbg_we=0100, data 0x00AB0000 to 0x10 while CPU idle → mem_we=0100 one cycle, no dbg_rd_valid; subsequent CPU LW 0x10 returns byte 2 = 0xAB.
- Back-to-back debug reads held asserted → grants spaced 2 cycles apart (IDLE→RESP→IDLE); no grant during RESP cycle even with CPU idle.
- dbg_req dropped at cycle 3 of starvation, reasserted → counter restarts from 0; forced grant 8 cycles after reassertion.
- rst_n asserted during RESP → dbg_rd_valid=0 asynchronously, state IDLE, counter 0; after release, first CPU access passes through unchanged.
